rgb_fade_sequencer: RTL and testbench

//  Sequences the R/G/B duty inputs of the triangle-PWM RGB LED driver. Steps through a

---
 rtl/rgb_pkg.sv | 31 +++
 rtl/rgb_tick_gen.sv | 27 ++
 rtl/rgb_fade_sequencer.sv | 148 ++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED path: sequencer state encoding, colour/channel
// widths, channel slice positions and the one-LSB channel step used while fading.
package rgb_pkg;

  localparam int COLOR_W = 24;
  localparam int CH_W    = 8;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FADE = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  // Moves one channel a single LSB toward its target; equal values are left alone,
  // so the result can never wrap past 0 or 255.
  function automatic logic [CH_W-1:0] step_toward(input logic [CH_W-1:0] cur,
                                                  input logic [CH_W-1:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Fade/hold time base: one-clk tick every TICK_DIV clocks, restartable with clr so
// the first tick after a clear lands exactly TICK_DIV clocks later.
module rgb_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Palette-driven colour sequencer: fades the R/G/B duties one LSB per tick toward each
// palette entry, holds it for hold_ticks ticks, then advances (one-shot or looping).
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int PAL_DEPTH = 8,
  parameter int AW        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic [AW:0]        num_entries,
  input  logic [15:0]        hold_ticks,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [CH_W-1:0]    r_duty,
  output logic [CH_W-1:0]    g_duty,
  output logic [CH_W-1:0]    b_duty,
  output logic               busy,
  output logic [AW-1:0]      cur_idx,
  output logic               done
);

  seq_state_t         state, state_nxt;
  logic [COLOR_W-1:0] pal [PAL_DEPTH];
  logic [COLOR_W-1:0] color, target, stepped;
  logic [AW:0]        num_q;
  logic [15:0]        hold_cnt;
  logic [AW-1:0]      idx_nxt;
  logic               done_nxt;
  logic               tick, start_ok, at_target, is_last;
  logic               do_load, do_step, do_hold_load, do_hold_dec;

  rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .tick (tick)
  );

  // Palette is deliberately not reset; a write lands at the next LOAD of that entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pal[wr_addr] <= wr_data;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_step
    assign stepped[ch*CH_W +: CH_W] = step_toward(color[ch*CH_W +: CH_W],
                                                  target[ch*CH_W +: CH_W]);
  end

  assign at_target = (color == target);
  assign is_last   = ({1'b0, cur_idx} == (num_q - 1'b1));
  assign busy      = (state != ST_IDLE);
  assign r_duty    = color[R_LSB +: CH_W];
  assign g_duty    = color[G_LSB +: CH_W];
  assign b_duty    = color[B_LSB +: CH_W];

  // stop outranks everything, including a start arriving in the same clock.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = cur_idx;
    done_nxt     = 1'b0;
    start_ok     = 1'b0;
    do_load      = 1'b0;
    do_step      = 1'b0;
    do_hold_load = 1'b0;
    do_hold_dec  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (num_entries != '0)) begin
            start_ok  = 1'b1;
            idx_nxt   = '0;
            state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          do_load   = 1'b1;
          state_nxt = ST_FADE;
        end
        ST_FADE: begin
          if (at_target) begin
            do_hold_load = 1'b1;
            state_nxt    = ST_HOLD;
          end else if (tick) begin
            do_step = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 16'd0) begin
            if (!is_last) begin
              idx_nxt   = cur_idx + 1'b1;
              state_nxt = ST_LOAD;
            end else if (loop_en) begin
              idx_nxt   = '0;
              state_nxt = ST_LOAD;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (tick) begin
            do_hold_dec = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      color    <= '0;
      target   <= '0;
      cur_idx  <= '0;
      num_q    <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_idx <= idx_nxt;
      done    <= done_nxt;
      if (start_ok) begin
        num_q <= num_entries;
      end
      if (do_load) begin
        target <= pal[cur_idx];
      end
      if (do_step) begin
        color <= stepped;
      end
      if (do_hold_load) begin
        hold_cnt <= hold_ticks;
      end else if (do_hold_dec) begin
        hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Randomised bench for rgb_fade_sequencer: a timeline model derives each clock's
// expected {busy, done, cur_idx, duties} from tick arithmetic and compares per cycle.
module tb_rgb_fade_sequencer;

  localparam int TD    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RW    = 29;

  // valid/ready does not apply here: start/stop/wr_en are single-clock strobes
  // driven on the falling edge and sampled by the DUT on the next rising edge.
  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [AW:0]   num_entries;
  logic [15:0]   hold_ticks;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic [7:0]    r_duty, g_duty, b_duty;
  logic          busy;
  logic [AW-1:0] cur_idx;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] exp_q[$];
  logic [23:0]   pal_m [DEPTH];
  logic [RW-1:0] last_rec;
  logic [RW-1:0] obs;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.TICK_DIV(TD), .PAL_DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .num_entries (num_entries),
    .hold_ticks  (hold_ticks),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .r_duty      (r_duty),
    .g_duty      (g_duty),
    .b_duty      (b_duty),
    .busy        (busy),
    .cur_idx     (cur_idx),
    .done        (done)
  );

  assign obs = {busy, done, cur_idx, r_duty, g_duty, b_duty};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (busy,done,idx,rgb)", tag, got, exp);
    end
  endtask

  // n-th tick edge strictly after edge a (edges counted from the start edge).
  function automatic int nth_tick(input int a, input int n);
    return (a / TD + n) * TD;
  endfunction

  function automatic int ticks_in(input int a, input int b);
    return (b <= a) ? 0 : (b / TD - a / TD);
  endfunction

  function automatic logic [7:0] moved(input logic [7:0] from, input logic [7:0] to,
                                       input int k);
    int f, t;
    f = int'(from);
    t = int'(to);
    if (t > f) return 8'(f + ((k < t - f) ? k : t - f));
    else       return 8'(f - ((k < f - t) ? k : f - t));
  endfunction

  function automatic int dist8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  // Builds exp_q[m] = outputs after the m-th rising edge, edge 0 being the start edge.
  task automatic build_trace(input int num, input int hold, input bit lp, input int max_cyc,
                             input bit do_wr, input int wr_a, input logic [23:0] wr_d,
                             input int abort_kind, input int abort_edge,
                             output int ae_o, output int we_o);
    int e, j, fe, a, d, fe0, we, ae, k;
    logic [23:0] base, tgt, c;
    logic [RW-1:0] prev;
    exp_q.delete();
    e = 0; j = 0; fe0 = -1; we = 1 << 30;
    base = last_rec[23:0];
    while (exp_q.size() < max_cyc) begin
      if (do_wr && we <= e) pal_m[wr_a] = wr_d;
      tgt = pal_m[j];
      d = dist8(base[23:16], tgt[23:16]);
      if (dist8(base[15:8], tgt[15:8]) > d) d = dist8(base[15:8], tgt[15:8]);
      if (dist8(base[7:0], tgt[7:0]) > d)   d = dist8(base[7:0], tgt[7:0]);
      fe = (d == 0) ? e + 2 : nth_tick(e + 1, d) + 1;
      a  = (hold == 0) ? fe + 1 : nth_tick(fe, hold) + 1;
      if (fe0 < 0) begin
        fe0 = fe;
        we  = fe + 1;
      end
      for (int m = e; m < a && exp_q.size() < max_cyc; m++) begin
        k = ticks_in(e + 1, m);
        c = {moved(base[23:16], tgt[23:16], k), moved(base[15:8], tgt[15:8], k),
             moved(base[7:0], tgt[7:0], k)};
        exp_q.push_back({1'b1, 1'b0, 3'(j), c});
      end
      base = tgt;
      if (j == num - 1) begin
        if (lp) begin
          j = 0;
        end else begin
          for (int m = a; m < a + 4; m++) exp_q.push_back({1'b0, (m == a), 3'(j), tgt});
          break;
        end
      end else begin
        j++;
      end
      e = a;
    end
    ae_o = -1;
    if (abort_kind != 0) begin
      ae = (abort_edge < 0) ? fe0 + 2 : abort_edge;
      if (ae >= 1 && ae < exp_q.size()) begin
        prev = exp_q[ae - 1];
        for (int m = ae; m < exp_q.size(); m++)
          exp_q[m] = (abort_kind == 1) ? {2'b00, prev[26:0]} : '0;
        while (exp_q.size() > ae + 4) void'(exp_q.pop_back());
        ae_o = ae;
      end
    end
    we_o = (do_wr && we < exp_q.size()) ? we : -1;
    if (we_o >= 0) pal_m[wr_a] = wr_d;
  endtask

  task automatic write_pal(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    pal_m[a] = d;
  endtask

  task automatic run_seq(input string name, input int num, input int hold, input bit lp,
                         input int max_cyc, input int abort_kind, input int abort_edge,
                         input bit do_wr, input int wr_a, input logic [23:0] wr_d);
    int ae, we, n;
    logic [RW-1:0] e;
    build_trace(num, hold, lp, max_cyc, do_wr, wr_a, wr_d, abort_kind, abort_edge, ae, we);
    n = exp_q.size();
    @(negedge clk);
    num_entries = 4'(num); hold_ticks = 16'(hold); loop_en = lp; start = 1'b1;
    @(posedge clk);
    for (int m = 0; m < n; m++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; rst = 1'b0; wr_en = 1'b0;
      if (m == 0) num_entries = 4'($urandom_range(0, 8));
      e = exp_q.pop_front();
      check(name, {3'b0, obs}, {3'b0, e});
      last_rec = e;
      if (m + 1 == ae) begin
        if (abort_kind == 1) stop = 1'b1;
        else rst = 1'b1;
      end
      if (m + 1 == we) begin
        wr_en = 1'b1; wr_addr = 3'(wr_a); wr_data = wr_d;
      end
      if (m + 1 == 2) start = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int num, hold, ae;
    bit lp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_entries = '0;
    hold_ticks = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", {3'b0, obs}, 32'd0);
    rst = 1'b0;
    last_rec = '0;

    write_pal(0, 24'h030000);
    run_seq("oneshot_red", 1, 2, 1'b0, 100000, 0, 0, 1'b0, 0, '0);

    write_pal(0, 24'h0000FF);
    write_pal(1, 24'h000000);
    run_seq("loop_blue", 2, 1, 1'b1, 2310, 1, 2300, 1'b0, 0, '0);

    write_pal(0, 24'h102030);
    run_seq("mixed_pre", 1, 0, 1'b0, 100000, 0, 0, 1'b0, 0, '0);
    write_pal(0, 24'h12202E);
    run_seq("mixed_dir", 1, 1, 1'b0, 100000, 0, 0, 1'b0, 0, '0);

    write_pal(0, 24'h000000);
    run_seq("to_black", 1, 0, 1'b0, 100000, 0, 0, 1'b0, 0, '0);
    write_pal(0, 24'h0A0000);
    run_seq("stop_fade", 1, 0, 1'b0, 100000, 1, 21, 1'b0, 0, '0);
    check("stop_r5", 32'(last_rec[23:16]), 32'h05);
    run_seq("resume", 1, 1, 1'b0, 100000, 0, 0, 1'b0, 0, '0);

    @(negedge clk);
    num_entries = '0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("num_zero", {3'b0, obs}, {3'b0, 2'b00, last_rec[26:0]});
    end

    for (int i = 0; i < 4; i++) write_pal(i, last_rec[23:0]);
    run_seq("same_hold0", 4, 0, 1'b0, 100000, 0, 0, 1'b0, 0, '0);

    write_pal(0, 24'($urandom));
    write_pal(1, 24'($urandom));
    run_seq("wr_in_hold", 2, 3, 1'b0, 100000, 0, 0, 1'b1, 1, 24'($urandom));
    run_seq("rst_in_hold", 2, 2, 1'b0, 100000, 2, -1, 1'b0, 0, '0);

    for (int r = 0; r < 6; r++) begin
      num  = $urandom_range(1, 4);
      hold = $urandom_range(0, 3);
      lp   = 1'($urandom_range(0, 1));
      for (int i = 0; i < num; i++) write_pal(i, 24'($urandom));
      ae = $urandom_range(3, 1500);
      if (lp) run_seq("rand_loop", num, hold, 1'b1, 1600, 1, ae, 1'b0, 0, '0);
      else    run_seq("rand_once", num, hold, 1'b0, 100000, 0, 0, 1'b0, 0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
